display_scan_ctrl: RTL



---
 rtl/display_scan_ctrl.sv | 56 +++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed seven-segment digit scanner with dwell, digit masking and frame flag.
// Define SCAN_BLANK_EN to blank CAT for the first BLANK_CYCLES of every slot.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int SEL_W        = $clog2(N_DIGITS),
  parameter int DWELL_CYCLES = 1,
  parameter int BLANK_CYCLES = 0,
  parameter int CAT_ACTIVE   = 1
) (
  input  logic                slow_clock,
  input  logic                reset,
  input  logic [N_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]    SEL,
  output logic [N_DIGITS-1:0] CAT,
  output logic                frame_start
);
  localparam int CNT_W = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_ON = 1;
`else
  localparam int BLANK_ON = 0;
`endif
  localparam int BLANK_N = BLANK_ON != 0 ? BLANK_CYCLES : 0;
  localparam logic ACT = CAT_ACTIVE != 0;
  logic [SEL_W-1:0] sel, nxt, j;
  logic [CNT_W-1:0] cnt;
  logic [N_DIGITS-1:0] hot;
  logic on;
  assign SEL = sel;
  // Descending search so the nearest enabled successor wins; sel itself is tried last.
  always_comb begin
    nxt = sel;
    j = '0;
    for (int k = N_DIGITS; k >= 1; k--) begin
      j = SEL_W'((int'(sel) + k) % N_DIGITS);
      if (digit_en[j]) nxt = j;
    end
  end
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      sel <= '0;
      cnt <= '0;
      frame_start <= 1'b0;
    end else if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
      cnt <= '0;
      sel <= nxt;
      frame_start <= |digit_en && nxt <= sel;
    end else begin
      cnt <= cnt + CNT_W'(1);
      frame_start <= 1'b0;
    end
  end
  assign on = !reset && digit_en[sel] && !(int'(cnt) < BLANK_N);
  assign hot = on ? {1'b1, {(N_DIGITS-1){1'b0}}} >> sel : '0;
  assign CAT = ACT ? hot : ~hot;
endmodule
